hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RV32 core.
- Consumes hazard indications: load-use from the EX-stage forwarding unit, data-memory wait, and taken branch resolved in EX.
- Drives per-stage stall, bubble and flush controls so operand forwarding always sees a legal pipeline state.
- Owns the post-branch fetch-squash window and the data-memory wait watchdog.

Parameters:
FETCH_LAT, 1, cycles of in-flight fetch that must be squashed after a taken branch (1..7)
MEM_TIMEOUT, 255, cycles in MEM_WAIT before mem_timeout_err sets (1..65535)

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-high reset
load_use_hazard  input  1  load in MEM, dependent consumer in EX
dmem_req  input  1  MEM stage has an outstanding load/store
dmem_ack  input  1  data memory completes the access this cycle
branch_taken_EX  input  1  taken branch/jump resolved in EX this cycle
stall_IF  output  1  hold PC and IF/ID
stall_ID  output  1  hold ID/EX
stall_EX  output  1  hold EX/MEM input side; EX instruction stays in EX
stall_MEM  output  1  hold MEM/WB
bubble_MEM  output  1  load NOP into EX/MEM
bubble_WB  output  1  load NOP into MEM/WB
flush_IFID  output  1  replace IF/ID with NOP
flush_IDEX  output  1  replace ID/EX with NOP
mem_timeout_err  output  1  sticky: MEM_WAIT exceeded MEM_TIMEOUT
perf_load_use  output  32  load-use stall count (optional feature)
perf_mem_wait  output  32  memory-wait cycle count (optional feature)
perf_flush  output  32  taken-branch flush count (optional feature)

Behaviour:
- Reset (async, rst=1): state=RUN, drain_cnt=0, wait_cnt=0, mem_timeout_err=0, perf counters=0. All control outputs are 0 while rst is high.
- States: RUN, MEM_WAIT, DRAIN. Control outputs are combinational from state and inputs, so there is zero latency.
- Per-cycle priority: MEM wait > load-use > branch flush.
- MEM wait condition (RUN or DRAIN): dmem_req=1 and dmem_ack=0.
  - Assert stall_IF, stall_ID, stall_EX, stall_MEM and bubble_WB.
  - Next state is MEM_WAIT; the prior state is recorded in ret_drain.
- MEM_WAIT:
  - Same freeze outputs while dmem_ack=0.
  - wait_cnt increments and saturates at MEM_TIMEOUT; when it reaches MEM_TIMEOUT, mem_timeout_err sets and stays set until rst.
  - On dmem_ack=1: freeze outputs are 0 that cycle (the access completes), wait_cnt clears, next state is DRAIN if ret_drain=1 with drain_cnt nonzero, else RUN.
  - load_use_hazard and branch_taken_EX are ignored in MEM_WAIT.
- Load-use (RUN/DRAIN, no MEM wait): stall_IF=stall_ID=stall_EX=1 and bubble_MEM=1 for exactly that cycle. No state change; WB forwarding resolves the operand next cycle.
- Taken branch:
  - Honoured only when stall_EX=0 in the same cycle.
  - Assert flush_IFID=flush_IDEX=1.
  - If FETCH_LAT>0: drain_cnt=FETCH_LAT and next state is DRAIN.
- DRAIN:
  - Assert flush_IFID each cycle and decrement drain_cnt; return to RUN when drain_cnt reaches 0.
  - A new honoured branch in DRAIN reloads drain_cnt=FETCH_LAT.
  - drain_cnt holds while frozen (MEM_WAIT) or load-use stalled.
- Load-use and branch in the same cycle: the load-use stall wins and the branch is not honoured. The branch re-presents next cycle because EX was held.

Optional Feature:
- HAZARD_PERF_EN defined:
  - perf_load_use increments per load-use stall cycle.
  - perf_mem_wait increments per frozen cycle.
  - perf_flush increments per honoured branch.
  - All three are 32-bit, wrap at 2^32, and clear on rst.
- HAZARD_PERF_EN undefined: the three perf ports exist, are tied to 0, and no counter flops are generated.

Decomposition:
- hazard_pkg:
  - hz_state_e enum {RUN, MEM_WAIT, DRAIN}, 2-bit encoding.
  - DRAIN_W=3 and WAIT_W=16 width constants.
  - Typedef hz_ctrl_t, a packed struct of the eight control outputs.
- Sub-module hazard_perf_cnt: one 32-bit saturating-free counter with enable. It is instantiated three times under HAZARD_PERF_EN.

Test Plan:
- Reset mid-DRAIN: assert rst with drain_cnt=1 -> all outputs 0 immediately, state RUN after release.
- Load-use: load_use_hazard=1 for one cycle in RUN -> stall_IF/ID/EX=1 and bubble_MEM=1 for exactly 1 cycle, next cycle all 0; perf_load_use=1.
- Memory wait: dmem_req=1, ack after 4 cycles -> stall_MEM=1 and bubble_WB=1 for 4 cycles, 0 on the ack cycle; perf_mem_wait=4; mem_timeout_err=0.
- Timeout: MEM_TIMEOUT=8, ack withheld 20 cycles -> mem_timeout_err rises on the 8th wait cycle and stays 1 after ack.
- Branch with FETCH_LAT=2 -> flush_IFID=1 for 3 consecutive cycles, flush_IDEX=1 for the first only; a second branch in cycle 2 extends flush_IFID to cycle 4.
- Branch coincident with load_use_hazard -> no flush that cycle; flush asserted next cycle; perf_flush=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states, counter widths
// and the bundled per-stage control word.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2
  } hz_state_e;

  localparam int unsigned DRAIN_W = 3;
  localparam int unsigned WAIT_W  = 16;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic bubble_mem;
    logic bubble_wb;
    logic flush_ifid;
    logic flush_idex;
  } hz_ctrl_t;

  // Whole pipeline held while data memory is busy; WB receives a NOP.
  function automatic hz_ctrl_t hz_freeze();
    hz_ctrl_t c;
    c           = '0;
    c.stall_if  = 1'b1;
    c.stall_id  = 1'b1;
    c.stall_ex  = 1'b1;
    c.stall_mem = 1'b1;
    c.bubble_wb = 1'b1;
    return c;
  endfunction

  // Front end and EX held for one cycle; MEM receives a NOP.
  function automatic hz_ctrl_t hz_load_use();
    hz_ctrl_t c;
    c            = '0;
    c.stall_if   = 1'b1;
    c.stall_id   = 1'b1;
    c.stall_ex   = 1'b1;
    c.bubble_mem = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// 32-bit event counter with enable, wrapping at 2^32.
// Only built when HAZARD_PERF_EN is defined; otherwise the module is absent
// and the sequencer ties its performance ports to zero.
`ifdef HAZARD_PERF_EN
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] count
);

  // Count one per enabled cycle; cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/hazard_stall_ctrl.sv
// Central stall/bubble/flush sequencer for the 5-stage RV32 pipeline.
// Priority each cycle: data-memory wait > load-use > taken-branch flush.
// Owns the post-branch fetch-squash window (DRAIN) and the memory-wait
// watchdog. Optional performance counters are enabled by HAZARD_PERF_EN.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned FETCH_LAT   = 1,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_use_hazard,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  input  logic        branch_taken_EX,
  output logic        stall_IF,
  output logic        stall_ID,
  output logic        stall_EX,
  output logic        stall_MEM,
  output logic        bubble_MEM,
  output logic        bubble_WB,
  output logic        flush_IFID,
  output logic        flush_IDEX,
  output logic        mem_timeout_err,
  output logic [31:0] perf_load_use,
  output logic [31:0] perf_mem_wait,
  output logic [31:0] perf_flush
);

  localparam logic [DRAIN_W-1:0] LAT_V     = DRAIN_W'(FETCH_LAT);
  localparam logic [WAIT_W-1:0]  TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  hz_state_e            state_q, state_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic                 ret_drain_q, ret_drain_d;
  logic                 err_q, err_d;
  logic                 frozen;
  hz_ctrl_t             ctrl;

  // State, squash counter, wait watchdog and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      drain_q     <= '0;
      wait_q      <= '0;
      ret_drain_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      wait_q      <= wait_d;
      ret_drain_q <= ret_drain_d;
      err_q       <= err_d;
    end
  end

  // Next state and zero-latency controls; every frozen cycle (including the
  // one that enters MEM_WAIT) advances the watchdog.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    wait_d      = wait_q;
    ret_drain_d = ret_drain_q;
    err_d       = err_q;
    ctrl        = '0;
    frozen      = 1'b0;
    if (!rst) begin
      case (state_q)
        MEM_WAIT: begin
          if (dmem_ack) begin
            wait_d  = '0;
            state_d = (ret_drain_q && (drain_q != '0)) ? DRAIN : RUN;
          end else begin
            frozen = 1'b1;
          end
        end
        default: begin
          if (dmem_req && !dmem_ack) begin
            frozen      = 1'b1;
            ret_drain_d = (state_q == DRAIN);
            state_d     = MEM_WAIT;
          end else if (load_use_hazard) begin
            ctrl = hz_load_use();
          end else if (branch_taken_EX) begin
            ctrl.flush_ifid = 1'b1;
            ctrl.flush_idex = 1'b1;
            if (FETCH_LAT > 0) begin
              drain_d = LAT_V;
              state_d = DRAIN;
            end
          end else if (state_q == DRAIN) begin
            ctrl.flush_ifid = 1'b1;
            drain_d         = drain_q - DRAIN_W'(1);
            if (drain_d == '0) begin
              state_d = RUN;
            end
          end
        end
      endcase
      if (frozen) begin
        ctrl = hz_freeze();
        if (wait_q != TIMEOUT_V) begin
          wait_d = wait_q + WAIT_W'(1);
        end
        if (wait_d == TIMEOUT_V) begin
          err_d = 1'b1;
        end
      end
    end
  end

  assign stall_IF        = ctrl.stall_if;
  assign stall_ID        = ctrl.stall_id;
  assign stall_EX        = ctrl.stall_ex;
  assign stall_MEM       = ctrl.stall_mem;
  assign bubble_MEM      = ctrl.bubble_mem;
  assign bubble_WB       = ctrl.bubble_wb;
  assign flush_IFID      = ctrl.flush_ifid;
  assign flush_IDEX      = ctrl.flush_idex;
  assign mem_timeout_err = err_q;

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt u_perf_load_use (
    .clk   (clk),
    .rst   (rst),
    .en    (ctrl.bubble_mem),
    .count (perf_load_use)
  );

  hazard_perf_cnt u_perf_mem_wait (
    .clk   (clk),
    .rst   (rst),
    .en    (ctrl.stall_mem),
    .count (perf_mem_wait)
  );

  hazard_perf_cnt u_perf_flush (
    .clk   (clk),
    .rst   (rst),
    .en    (ctrl.flush_idex),
    .count (perf_flush)
  );
`else
  assign perf_load_use = '0;
  assign perf_mem_wait = '0;
  assign perf_flush    = '0;
`endif

endmodule
